// File: rtl/frame_buffer_clearer_if.sv
// Avalon-MM burst-write bus between the frame buffer clearer and an SDRAM port.
interface frame_buffer_clearer_if;
    logic [28:0] address;
    logic [7:0]  burstcount;
    logic        waitrequest;
    logic [63:0] writedata;
    logic [7:0]  byteenable;
    logic        write;

    modport master (
        output address,
        output burstcount,
        input  waitrequest,
        output writedata,
        output byteenable,
        output write
    );

    modport slave (
        input  address,
        input  burstcount,
        output waitrequest,
        input  writedata,
        input  byteenable,
        input  write
    );
endinterface

// File: rtl/frame_buffer_clearer.sv
// Frame buffer clearer: Avalon-MM burst-write master that fills one frame
// buffer with a constant 32-bit colour, then pulses done.
module frame_buffer_clearer #(
    parameter logic [29:0] ADDRESS      = 30'h3800_0000,
    parameter int unsigned LENGTH       = 1536000,
    parameter int unsigned BURST_LENGTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   buffer_index,
    input  logic [31:0]            color,
    input  logic                   abort,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            debug_value0,
    frame_buffer_clearer_if.master avm
);

    localparam int unsigned TOTAL_WORDS  = LENGTH / 8;
    localparam int unsigned TOTAL_BURSTS = TOTAL_WORDS / BURST_LENGTH;

    // Base word addresses computed at full width before truncation to 29 bits.
    localparam logic [63:0] BASE_BYTE0 = 64'(ADDRESS);
    localparam logic [63:0] BASE_BYTE1 = 64'(ADDRESS) + 64'(LENGTH);
    localparam logic [28:0] BASE_WORD0 = 29'(BASE_BYTE0 >> 3);
    localparam logic [28:0] BASE_WORD1 = 29'(BASE_BYTE1 >> 3);

    localparam logic [7:0]  BURST_CNT  = 8'(BURST_LENGTH);
    localparam logic [6:0]  LAST_BEAT  = 7'(BURST_LENGTH - 1);
    localparam logic [31:0] LAST_BURST = 32'(TOTAL_BURSTS - 1);
    localparam logic [28:0] ADDR_STEP  = 29'(BURST_LENGTH);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t      state_q, state_d;
    logic [28:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [6:0]  beat_q, beat_d;
    logic [31:0] burst_q, burst_d;
    logic [31:0] dbg_q, dbg_d;
    logic        write_q, write_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        beat_accepted;

    assign beat_accepted = write_q && !avm.waitrequest;

    // State and registered outputs; reset forces an idle bus immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            beat_q  <= '0;
            burst_q <= '0;
            dbg_q   <= '0;
            write_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            beat_q  <= beat_d;
            burst_q <= burst_d;
            dbg_q   <= dbg_d;
            write_q <= write_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: latch on start, advance per accepted beat, and only
    // consider abort at a burst boundary so bursts are never truncated.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        beat_d  = beat_q;
        burst_d = burst_q;
        dbg_d   = dbg_q;
        write_d = write_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    wdata_d = {color, color};
                    addr_d  = buffer_index ? BASE_WORD1 : BASE_WORD0;
                    beat_d  = '0;
                    burst_d = '0;
                    dbg_d   = '0;
                    write_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (beat_accepted) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        burst_d = burst_q + 32'd1;
                        dbg_d   = dbg_q + 32'd1;
                        if ((burst_q == LAST_BURST) || abort) begin
                            write_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            addr_d = addr_q + ADDR_STEP;
                        end
                    end else begin
                        beat_d = beat_q + 7'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign avm.address    = addr_q;
    assign avm.burstcount = BURST_CNT;
    assign avm.writedata  = wdata_q;
    assign avm.byteenable = 8'hFF;
    assign avm.write      = write_q;

    assign busy         = busy_q;
    assign done         = done_q;
    assign debug_value0 = dbg_q;

endmodule
